i2s_tx_param: RTL

// Parametrised I2S/left-justified stereo transmitter for the audio DAC path, single clock domain (input_clk = DAC MCLK).

---
 rtl/i2s_tx_param.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/i2s_tx_param.sv
// Stereo I2S / left-justified serial transmitter with a one-deep sample buffer.
// Generates the bit clock, word select and MSB-first data from input_clk; the buffer is loaded at each frame boundary.
module i2s_tx_param #(
  parameter int DATA_W    = 16,
  parameter int SLOT_W    = 32,
  parameter int MCLK_DIV  = 4,
  parameter int FORMAT_LJ = 0
) (
  input  logic                     input_clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] sample_l,
  input  logic signed [DATA_W-1:0] sample_r,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic                     mono_en,
  input  logic                     mute,
  input  logic                     underflow_clr,
  output logic                     dac_mclk,
  output logic                     serial_clk,
  output logic                     word_select,
  output logic                     sound_bit_out,
  output logic                     frame_start,
  output logic                     underflow
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = $clog2(MCLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(MCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE  = DIV_W'(MCLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] SLOT_LO   = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] WS_I2S_LO = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0] WS_I2S_HI = BIT_W'(FRAME_W - 2);

  logic [DIV_W-1:0]         div_cnt;
  logic [DIV_W-1:0]         div_nxt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [BIT_W-1:0]         bit_nxt;
  logic                     fall;
  logic                     boundary;
  logic                     hold_full;
  logic                     accept;
  logic signed [DATA_W-1:0] hold_l;
  logic signed [DATA_W-1:0] hold_r;
  logic signed [DATA_W-1:0] act_l;
  logic signed [DATA_W-1:0] act_r;
  logic signed [DATA_W-1:0] load_l;
  logic signed [DATA_W-1:0] load_r;
  logic signed [DATA_W-1:0] frame_l;
  logic signed [DATA_W-1:0] frame_r;

  // Serial bit for frame position pos; positions at or beyond DATA_W in a slot shift out to the zero pad.
  function automatic logic slot_bit(input logic [BIT_W-1:0] pos,
                                    input logic signed [DATA_W-1:0] left,
                                    input logic signed [DATA_W-1:0] right);
    logic [DATA_W-1:0] word;
    int                k;
    if (pos >= SLOT_LO) begin
      word = right;
      k    = int'(pos) - SLOT_W;
    end else begin
      word = left;
      k    = int'(pos);
    end
    word = word << k;
    return word[DATA_W-1];
  endfunction

  // I2S raises word_select one bit before the right slot and drops it one bit before the left slot.
  function automatic logic ws_for(input logic [BIT_W-1:0] pos);
    if (FORMAT_LJ != 0) return pos >= SLOT_LO;
    return (pos >= WS_I2S_LO) && (pos <= WS_I2S_HI);
  endfunction

  assign dac_mclk     = input_clk;
  assign fall         = (div_cnt == DIV_LAST);
  assign boundary     = fall && (bit_cnt == BIT_LAST);
  assign div_nxt      = fall ? '0 : div_cnt + 1'b1;
  assign bit_nxt      = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  assign sample_ready = !hold_full;
  assign accept       = sample_valid && !hold_full;

  always_comb begin
    load_l = '0;
    load_r = '0;
    if (hold_full && !mute) begin
      load_l = hold_l;
      load_r = mono_en ? hold_l : hold_r;
    end
    frame_l = boundary ? load_l : act_l;
    frame_r = boundary ? load_r : act_r;
  end

  // Bit-clock timing: data, word_select and bit position all move on the falling bit-clock edge.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      div_cnt       <= '0;
      bit_cnt       <= BIT_LAST;
      serial_clk    <= 1'b0;
      word_select   <= 1'b0;
      sound_bit_out <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      frame_start <= (div_nxt == DIV_LAST) && (bit_cnt == BIT_LAST);
      if (div_cnt == DIV_RISE) begin
        serial_clk <= 1'b1;
      end else if (fall) begin
        serial_clk <= 1'b0;
      end
      if (fall) begin
        bit_cnt       <= bit_nxt;
        word_select   <= ws_for(bit_nxt);
        sound_bit_out <= slot_bit(bit_nxt, frame_l, frame_r);
      end
    end
  end

  // Buffer control: set of underflow wins over a simultaneous clear.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
      act_l     <= '0;
      act_r     <= '0;
      underflow <= 1'b0;
    end else begin
      if (boundary) begin
        act_l <= load_l;
        act_r <= load_r;
      end
      if (boundary && hold_full) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end
      if (boundary && !hold_full) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge input_clk) begin
    if (accept) begin
      hold_l <= sample_l;
      hold_r <= sample_r;
    end
  end

endmodule
